uio_sum_responder: RTL and testbench

- Bus-turnaround responder for the bidirectional uio pins. The adder datapath uses these pins input-only; this block also drives them as outputs.
- A host loads two operands over uio_in with strobes and issues start.
- The block computes the sum, performs a bus turnaround, and drives the result back onto uio_out with uio_oe enabled until the host acknowledges.
- Sits beside the top-level pin wrapper; the wrapper maps the strobes onto ui_in bits and the status flags onto uo_out bits.

---
 rtl/uio_sum_responder.sv | 135 +++++++++++++
 tb/tb_uio_sum_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uio_sum_responder.sv
// ----------------------------------------------------------------------------
// uio_sum_responder
//
// Bus-turnaround responder for the bidirectional uio pins. A host loads two
// operands over uio_in (ld_a / ld_b), issues start, and the block computes
// A + B. After a configurable turnaround gap, it drives the result onto
// uio_out with uio_oe enabled. The block keeps driving until the host
// acknowledges, then holds one undriven RELEASE cycle before going idle.
//
// Handshake: valid=1 (with uio_oe all-ones) means uio_out/carry hold a stable
// result. The result stays stable for as long as valid is high. ack is the
// host's "taken" strobe and is only sampled while valid=1. The edge that
// samples ack=1 ends the transfer. ack seen at any other time has no effect.
//
// Parameters:
//   WIDTH       operand / bus width in bits
//   TURN_CYCLES idle cycles between CALC and DRIVE (0..15)
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   ld_a, ld_b        capture uio_in into operand A / B (IDLE only)
//   start             begin computation (IDLE only)
//   ack               host has read the result (DRIVE only)
//   uio_in            operand data from pins
//   uio_out, uio_oe   result data and all-or-nothing output enable
//   busy              high in every state except IDLE
//   valid, carry      result driven flag and carry-out of the sum
// ----------------------------------------------------------------------------
module uio_sum_responder #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             start,
  input  logic             ack,
  input  logic [WIDTH-1:0] uio_in,
  output logic [WIDTH-1:0] uio_out,
  output logic [WIDTH-1:0] uio_oe,
  output logic             busy,
  output logic             valid,
  output logic             carry
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_TURN    = 3'd2,
    S_DRIVE   = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  localparam logic [3:0] TURN_LD = 4'(TURN_CYCLES);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [3:0]       turn_q, turn_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      turn_q  <= turn_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    turn_d  = turn_q;
    unique case (state_q)
      S_IDLE: begin
        // Loads in the start cycle land before CALC reads A/B.
        if (ld_a) a_d = uio_in;
        if (ld_b) b_d = uio_in;
        if (start) state_d = S_CALC;
      end
      S_CALC: begin
        sum_d   = {1'b0, a_q} + {1'b0, b_q};
        turn_d  = TURN_LD;
        state_d = (TURN_CYCLES > 0) ? S_TURN : S_DRIVE;
      end
      S_TURN: begin
        // The counter holds the remaining TURN cycles including this one.
        if (turn_q <= 4'd1) begin
          turn_d  = '0;
          state_d = S_DRIVE;
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      S_DRIVE: begin
        if (ack) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs: decoded only from registered state and sum
  always_comb begin
    uio_out = '0;
    uio_oe  = '0;
    valid   = 1'b0;
    carry   = 1'b0;
    busy    = (state_q != S_IDLE);
    if (state_q == S_DRIVE) begin
      uio_oe  = '1;
      uio_out = sum_q[WIDTH-1:0];
      carry   = sum_q[WIDTH];
      valid   = 1'b1;
    end
  end

endmodule

// File: tb/tb_uio_sum_responder.sv
module tb_uio_sum_responder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_a, ld_b, start, ack;
  logic [7:0] uio_in;

  logic [7:0] uio_out, uio_oe;
  logic       busy, valid, carry;
  logic [7:0] uio_out_t0, uio_oe_t0;
  logic       busy_t0, valid_t0, carry_t0;
  logic [7:0] uio_out_t3, uio_oe_t3;
  logic       busy_t3, valid_t3, carry_t3;

  logic [8:0] exp_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  vec_t       vecs[8];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  uio_sum_responder #(.WIDTH(8), .TURN_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .start(start), .ack(ack),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .busy(busy),
    .valid(valid), .carry(carry)
  );

  uio_sum_responder #(.WIDTH(8), .TURN_CYCLES(0)) u_dut_t0 (
    .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .start(start), .ack(ack),
    .uio_in(uio_in), .uio_out(uio_out_t0), .uio_oe(uio_oe_t0), .busy(busy_t0),
    .valid(valid_t0), .carry(carry_t0)
  );

  uio_sum_responder #(.WIDTH(8), .TURN_CYCLES(3)) u_dut_t3 (
    .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .start(start), .ack(ack),
    .uio_in(uio_in), .uio_out(uio_out_t3), .uio_oe(uio_oe_t3), .busy(busy_t3),
    .valid(valid_t3), .carry(carry_t3)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called while DRIVE is being shown: scoreboard compare, hold, ack, release.
  task automatic finish_drive(input string tag, input int hold);
    logic [8:0] exp;
    int         bad;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    chk({tag, "_result"}, {23'd0, carry, uio_out}, {23'd0, exp});
    chk({tag, "_valid"}, {30'd0, valid, busy}, 32'd3);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (uio_out !== exp[7:0] || carry !== exp[8] || uio_oe !== 8'hFF || valid !== 1'b1) bad++;
    end
    chk({tag, "_hold_stable"}, bad, 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk({tag, "_release"}, {22'd0, uio_oe, busy, valid}, {22'd0, 8'h00, 1'b1, 1'b0});
    chk({tag, "_release_out"}, {23'd0, carry, uio_out}, 32'd0);
    step();
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Called just after the edge that sampled start.
  task automatic wait_drive(input string tag, input int hold);
    int cnt;
    chk({tag, "_calc_oe"}, {24'd0, uio_oe}, 32'd0);
    cnt = 0;
    while (uio_oe !== 8'hFF && cnt < 20) begin
      step();
      cnt++;
    end
    chk({tag, "_latency"}, cnt, 2);
    finish_drive(tag, hold);
  endtask

  task automatic run_sum(input bit load, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp, input string tag);
    if (load) begin
      uio_in = a; ld_a = 1'b1; step(); ld_a = 1'b0;
      uio_in = b; ld_b = 1'b1; step(); ld_b = 1'b0;
      uio_in = 8'h00;
    end
    exp_q.push_back(exp);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_drive(tag, 3);
  endtask

  // ---------------- test ----------------
  initial begin
    int         cnt;
    int         lat, lat0, lat3;
    logic [7:0] ra, rb;

    vecs[0] = '{a: 8'h12, b: 8'h34, exp: 9'h046};
    vecs[1] = '{a: 8'hFF, b: 8'h01, exp: 9'h100};
    vecs[2] = '{a: 8'h80, b: 8'h80, exp: 9'h100};
    vecs[3] = '{a: 8'h00, b: 8'h00, exp: 9'h000};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, exp: 9'h1FE};
    vecs[5] = '{a: 8'h7F, b: 8'h01, exp: 9'h080};
    for (int i = 6; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      vecs[i] = '{a: ra, b: rb, exp: {1'b0, ra} + {1'b0, rb}};
    end

    rst = 1'b1; ld_a = 1'b0; ld_b = 1'b0; start = 1'b0; ack = 1'b0; uio_in = 8'h00;
    #1;
    chk("reset_outputs", {21'd0, uio_oe, uio_out, busy, valid, carry}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_reset_outputs", {21'd0, uio_oe, uio_out, busy, valid, carry}, 32'd0);

    // Table-driven sums, including overflow cases
    for (int i = 0; i < 8; i++)
      run_sum(1'b1, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Inputs ignored while busy: ld_a/start pulsed in TURN and in DRIVE
    uio_in = 8'h21; ld_a = 1'b1; step(); ld_a = 1'b0;
    uio_in = 8'h13; ld_b = 1'b1; step(); ld_b = 1'b0;
    exp_q.push_back(9'h034);
    start = 1'b1; step(); start = 1'b0;    // edge 0 -> CALC
    step();                                // edge 1 -> TURN
    chk("ign_turn_oe", {24'd0, uio_oe}, 32'd0);
    uio_in = 8'hAA; ld_a = 1'b1; start = 1'b1;
    step();                                // edge 2 -> DRIVE
    ld_a = 1'b0; start = 1'b0; uio_in = 8'h00;
    chk("ign_drive_oe", {24'd0, uio_oe}, 32'h0FF);
    uio_in = 8'hAA; ld_a = 1'b1; start = 1'b1;
    step();
    ld_a = 1'b0; start = 1'b0; uio_in = 8'h00;
    finish_drive("ign", 3);
    run_sum(1'b0, 8'h00, 8'h00, 9'h034, "ign_restart");

    // ack held high from before start: one DRIVE cycle, then RELEASE, IDLE
    ack = 1'b1;
    exp_q.push_back(9'h034);
    start = 1'b1; step(); start = 1'b0;
    cnt = 0;
    while (uio_oe !== 8'hFF && cnt < 20) begin
      step();
      cnt++;
    end
    chk("ackhold_latency", cnt, 2);
    chk("ackhold_result", {23'd0, carry, uio_out}, {23'd0, exp_q.pop_front()});
    step();
    chk("ackhold_release", {23'd0, uio_oe, busy}, {23'd0, 8'h00, 1'b1});
    step();
    chk("ackhold_idle", {31'd0, busy}, 32'd0);
    ack = 1'b0;
    repeat (3) step();

    // Long DRIVE hold with ack low
    run_sum(1'b1, 8'h9C, 8'h2B, 9'h0C7, "hold100");
    exp_q.push_back(9'h0C7);
    start = 1'b1; step(); start = 1'b0;
    wait_drive("hold100b", 100);

    // Asynchronous reset in the middle of DRIVE
    run_sum(1'b1, 8'h40, 8'h05, 9'h045, "prereset");
    start = 1'b1; step(); start = 1'b0;
    cnt = 0;
    while (uio_oe !== 8'hFF && cnt < 20) begin
      step();
      cnt++;
    end
    chk("rst_mid_drive_oe", {24'd0, uio_oe}, 32'h0FF);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async", {21'd0, uio_oe, uio_out, busy, valid, carry}, 32'd0);
    #1;
    rst = 1'b0;
    run_sum(1'b0, 8'h00, 8'h00, 9'h000, "after_reset");

    // TURN_CYCLES sweep: loads in the start cycle, three instances in parallel
    rst = 1'b1; #1; rst = 1'b0;
    step();
    uio_in = 8'h05; ld_a = 1'b1; ld_b = 1'b1; start = 1'b1;
    step();                                // edge 0
    ld_a = 1'b0; ld_b = 1'b0; start = 1'b0; uio_in = 8'h00;
    lat = -1; lat0 = -1; lat3 = -1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (lat  < 0 && uio_oe    === 8'hFF) lat  = e;
      if (lat0 < 0 && uio_oe_t0 === 8'hFF) lat0 = e;
      if (lat3 < 0 && uio_oe_t3 === 8'hFF) lat3 = e;
    end
    chk("sweep_lat_t1", lat, 2);
    chk("sweep_lat_t0", lat0, 1);
    chk("sweep_lat_t3", lat3, 4);
    chk("sweep_res_t1", {23'd0, carry, uio_out}, 32'h00A);
    chk("sweep_res_t0", {23'd0, carry_t0, uio_out_t0}, 32'h00A);
    chk("sweep_res_t3", {23'd0, carry_t3, uio_out_t3}, 32'h00A);
    ack = 1'b1; step(); ack = 1'b0;
    chk("sweep_release", {29'd0, busy & ~valid, busy_t0 & ~valid_t0, busy_t3 & ~valid_t3}, 32'd7);
    step();
    chk("sweep_idle", {29'd0, busy, busy_t0, busy_t3}, 32'd0);

    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
